// File: rtl/nibble_bus_pkg.sv
// rtl/nibble_bus_pkg.sv - shared types and widths for the nibble bus scheduler
package nibble_bus_pkg;
  localparam int N_REQ = 4;
  localparam int SEL_W = 2;
  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;
endpackage

// File: rtl/nibble_bus_scheduler_if.sv
// rtl/nibble_bus_scheduler_if.sv - request/route inputs and bus control outputs of the scheduler
interface nibble_bus_scheduler_if;
  import nibble_bus_pkg::*;

  logic [N_REQ-1:0]       req;
  logic [N_REQ*SEL_W-1:0] dst_map;
  logic [N_REQ-1:0]       grant;
  logic [SEL_W-1:0]       mux_sel;
  logic [SEL_W-1:0]       demux_sel;
  logic                   bus_en;
  logic                   busy;

  // Requester side: raises requests and supplies the route map
  modport master (
    output req, dst_map,
    input  grant, mux_sel, demux_sel, bus_en, busy
  );

  // Scheduler side
  modport slave (
    input  req, dst_map,
    output grant, mux_sel, demux_sel, bus_en, busy
  );
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating-priority pick of the first active request at or after ptr
module rr_pick
  import nibble_bus_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [SEL_W-1:0] o_idx
);

  logic [SEL_W-1:0] w_cand;

  // Walk the rotation backwards so the candidate closest to ptr is assigned last and wins
  always_comb begin
    o_valid = |i_req;
    o_idx   = i_ptr;
    w_cand  = i_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = i_ptr + SEL_W'(k);
      if (i_req[w_cand]) begin
        o_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/nibble_bus_scheduler.sv
// rtl/nibble_bus_scheduler.sv - round-robin grant FSM driving mux/demux selects and bus enable
module nibble_bus_scheduler
  import nibble_bus_pkg::*;
#(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nibble_bus_scheduler_if.slave bus
);

  state_t           r_state, w_state;
  logic [N_REQ-1:0] r_grant, w_grant;
  logic [SEL_W-1:0] r_mux_sel, w_mux_sel;
  logic [SEL_W-1:0] r_demux_sel, w_demux_sel;
  logic             r_bus_en, w_bus_en;
  logic             r_busy, w_busy;
  logic [SEL_W-1:0] r_ptr, w_ptr;
  logic [CNT_W-1:0] r_cnt, w_cnt;

  logic             w_valid;
  logic [SEL_W-1:0] w_idx;

  rr_pick u_rr_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  // State, counter, pointer and all outputs are registered; reset drops the bus at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_mux_sel   <= '0;
      r_demux_sel <= '0;
      r_bus_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_ptr       <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state;
      r_grant     <= w_grant;
      r_mux_sel   <= w_mux_sel;
      r_demux_sel <= w_demux_sel;
      r_bus_en    <= w_bus_en;
      r_busy      <= w_busy;
      r_ptr       <= w_ptr;
      r_cnt       <= w_cnt;
    end
  end

  // Next state and next outputs; selects are left untouched outside a new grant so the demux never glitches
  always_comb begin
    w_state     = r_state;
    w_grant     = r_grant;
    w_mux_sel   = r_mux_sel;
    w_demux_sel = r_demux_sel;
    w_bus_en    = r_bus_en;
    w_busy      = r_busy;
    w_ptr       = r_ptr;
    w_cnt       = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_state     = GRANT;
          w_grant     = N_REQ'(1) << w_idx;
          w_mux_sel   = w_idx;
          w_demux_sel = bus.dst_map[w_idx*SEL_W +: SEL_W];
          w_bus_en    = 1'b1;
          w_busy      = 1'b1;
          w_cnt       = '0;
        end
      end
      GRANT: begin
        if ((r_cnt == CNT_W'(HOLD_CYCLES - 1)) || !bus.req[r_mux_sel]) begin
          w_state  = GAP;
          w_grant  = '0;
          w_bus_en = 1'b0;
          w_ptr    = r_mux_sel + SEL_W'(1);
          w_cnt    = '0;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
          w_state = IDLE;
          w_busy  = 1'b0;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state  = IDLE;
        w_grant  = '0;
        w_bus_en = 1'b0;
        w_busy   = 1'b0;
        w_cnt    = '0;
      end
    endcase
  end

  assign bus.grant     = r_grant;
  assign bus.mux_sel   = r_mux_sel;
  assign bus.demux_sel = r_demux_sel;
  assign bus.bus_en    = r_bus_en;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_nibble_bus_scheduler.sv
// tb/tb_nibble_bus_scheduler.sv - randomized model-checked bench for the nibble bus scheduler
module tb_nibble_bus_scheduler;
  localparam int HOLD = 8;
  localparam int GAPC = 1;
  localparam logic [15:0] SW = 16'h6A59;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  nibble_bus_scheduler_if u_if ();

  nibble_bus_scheduler #(
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAPC),
    .CNT_W       (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: bus phase (0 idle, 1 owned, 2 dead gap), cycles left in the phase, owner, its route, next start
  int m_phase, m_left, m_owner, m_route, m_ptr;

  // Advance the reference one clock using the inputs present at the edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_left = 0; m_owner = 0; m_route = 0; m_ptr = 0;
    end else begin
      case (m_phase)
        0: begin
          if (u_if.req != 4'b0) begin
            for (int k = 3; k >= 0; k--)
              if (u_if.req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
            m_route = (u_if.dst_map >> (2 * m_owner)) & 3;
            m_phase = 1;
            m_left  = HOLD;
          end
        end
        1: begin
          m_left = m_left - 1;
          if (m_left == 0 || !u_if.req[m_owner]) begin
            m_phase = 2;
            m_left  = GAPC;
            m_ptr   = (m_owner + 1) % 4;
          end
        end
        default: begin
          m_left = m_left - 1;
          if (m_left == 0) m_phase = 0;
        end
      endcase
    end
  end

  // Compare every output, the bus invariant and the resulting datapath against the reference
  always @(negedge clk) begin
    if (rst_n) begin
      logic [15:0] led_dut, led_exp;
      chk("grant",     16'(u_if.grant),     (m_phase == 1) ? 16'(1 << m_owner) : 16'h0);
      chk("bus_en",    16'(u_if.bus_en),    16'(m_phase == 1));
      chk("busy",      16'(u_if.busy),      16'(m_phase != 0));
      chk("mux_sel",   16'(u_if.mux_sel),   16'(m_owner));
      chk("demux_sel", 16'(u_if.demux_sel), 16'(m_route));
      if (u_if.bus_en)
        chk("onehot_inv", 16'(u_if.grant), 16'(4'b0001 << u_if.mux_sel));
      led_dut = u_if.bus_en ? (16'((SW >> (4 * u_if.mux_sel)) & 16'hF) << (4 * u_if.demux_sel)) : 16'h0;
      led_exp = (m_phase == 1) ? (16'((SW >> (4 * m_owner)) & 16'hF) << (4 * m_route)) : 16'h0;
      chk("led", led_dut, led_exp);
    end
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit(input string nm, input logic [3:0] g, input logic [1:0] ms,
                     input logic [1:0] ds, input logic en, input logic bz);
    chk({nm, ".grant"}, 16'(u_if.grant), 16'(g));
    chk({nm, ".mux"},   16'(u_if.mux_sel), 16'(ms));
    chk({nm, ".demux"}, 16'(u_if.demux_sel), 16'(ds));
    chk({nm, ".en"},    16'(u_if.bus_en), 16'(en));
    chk({nm, ".busy"},  16'(u_if.busy), 16'(bz));
  endtask

  initial begin
    u_if.req = 4'hF;
    u_if.dst_map = 8'b00_01_10_11;
    #1 rst_n = 1'b0;
    nclk(2); #1;
    lit("reset", 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    nclk(1);
    lit("first", 4'b0001, 2'd0, 2'd3, 1'b1, 1'b1);
    nclk(7);
    lit("hold8", 4'b0001, 2'd0, 2'd3, 1'b1, 1'b1);
    nclk(1);
    lit("gap", 4'b0000, 2'd0, 2'd3, 1'b0, 1'b1);
    nclk(1);
    lit("idle", 4'b0000, 2'd0, 2'd3, 1'b0, 1'b0);
    nclk(1);
    lit("rr1", 4'b0010, 2'd1, 2'd2, 1'b1, 1'b1);
    nclk(10);
    lit("rr2", 4'b0100, 2'd2, 2'd1, 1'b1, 1'b1);
    nclk(10);
    lit("rr3", 4'b1000, 2'd3, 2'd0, 1'b1, 1'b1);
    nclk(10);
    lit("rr0", 4'b0001, 2'd0, 2'd3, 1'b1, 1'b1);

    // Early release and route sampling
    #1 rst_n = 1'b0;
    u_if.req = 4'b0100;
    u_if.dst_map = 8'hE4;
    nclk(1); #1 rst_n = 1'b1;
    nclk(1);
    lit("er_grant", 4'b0100, 2'd2, 2'd2, 1'b1, 1'b1);
    nclk(1); #1 u_if.dst_map = 8'h1B;
    nclk(1);
    lit("route_hold", 4'b0100, 2'd2, 2'd2, 1'b1, 1'b1);
    #1 u_if.req = 4'b0000;
    nclk(1);
    lit("er_gap", 4'b0000, 2'd2, 2'd2, 1'b0, 1'b1);
    nclk(1);
    lit("er_idle", 4'b0000, 2'd2, 2'd2, 1'b0, 1'b0);
    #1 u_if.req = 4'b0100;
    nclk(1);
    lit("new_route", 4'b0100, 2'd2, 2'd1, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a grant
    #1 u_if.req = 4'hF;
    nclk(4);
    #2 rst_n = 1'b0;
    #1;
    lit("async_rst", 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0);
    nclk(1); #1 rst_n = 1'b1;
    nclk(1);
    lit("ptr_reset", 4'b0001, 2'd0, 2'd3, 1'b1, 1'b1);

    // Randomized traffic: persistent requests, toggling requests, route changes
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if (c < 400) u_if.req = 4'hF;
      else begin
        for (int b = 0; b < 4; b++)
          if ($urandom_range(0, 7) == 0) u_if.req[b] = ~u_if.req[b];
        if (c > 2500 && c < 2700) u_if.req = 4'b0010;
      end
      if ($urandom_range(0, 19) == 0) u_if.dst_map = 8'($urandom);
    end

    nclk(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
